// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES job arbiter: FSM states, legal key-size
// codes and the timeout-counter width derivation.
package aes_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arbState_t;

    localparam int DATA_W = 128;

    localparam logic [2:0] KEY_SIZE_128 = 3'b100;
    localparam logic [2:0] KEY_SIZE_192 = 3'b010;
    localparam logic [2:0] KEY_SIZE_256 = 3'b001;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // The counter runs 0..cycles-1 while BUSY, so clog2(cycles) bits are enough.
    function automatic int timeoutCntWidth(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic logic isLegalKeySize(input logic [2:0] keySize);
        return (keySize == KEY_SIZE_128) || (keySize == KEY_SIZE_192) ||
               (keySize == KEY_SIZE_256);
    endfunction

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Request, response and core-side signals of the AES job arbiter.
// master = requesters plus AES core environment, slave = the arbiter.
interface aes_job_arbiter_if;
    import aes_arb_pkg::*;

    logic [1:0]        reqValid;
    logic [1:0]        reqReady;
    logic [1:0]        reqEncOrDec;
    logic [2:0]        reqKeySize0;
    logic [2:0]        reqKeySize1;
    logic [DATA_W-1:0] reqMessage0;
    logic [DATA_W-1:0] reqMessage1;

    logic              coreStart;
    logic              coreEncOrDec;
    logic [2:0]        coreKeySize;
    logic [DATA_W-1:0] coreMessageIn;
    logic              coreDone;
    logic [DATA_W-1:0] coreMessageOut;

    logic [1:0]        rspValid;
    logic [1:0]        rspReady;
    logic [DATA_W-1:0] rspMessage;
    logic              rspError;
    logic              busy;

    modport master (
        output reqValid, reqEncOrDec, reqKeySize0, reqKeySize1, reqMessage0, reqMessage1,
        output coreDone, coreMessageOut, rspReady,
        input  reqReady, coreStart, coreEncOrDec, coreKeySize, coreMessageIn,
        input  rspValid, rspMessage, rspError, busy
    );

    modport slave (
        input  reqValid, reqEncOrDec, reqKeySize0, reqKeySize1, reqMessage0, reqMessage1,
        input  coreDone, coreMessageOut, rspReady,
        output reqReady, coreStart, coreEncOrDec, coreKeySize, coreMessageIn,
        output rspValid, rspMessage, rspError, busy
    );

endinterface

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin selector: a lone requester wins; on a tie the requester
// that did not win last time gets the grant.
module aes_rr_arbiter (
    input  logic [1:0] reqValid,
    input  logic       lastGrant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (reqValid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES core between two requesters, one job in flight at a time.
// Optional BUSY watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_job_arbiter
    import aes_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    aes_job_arbiter_if.slave bus
);

    arbState_t         state;
    arbState_t         stateNext;
    logic              lastGrant;
    logic              owner;
    logic [1:0]        grant;
    logic [1:0]        ownerMask;
    logic              accept;
    logic              keyLegal;
    logic              timeoutHit;
    logic              encOrDecQ;
    logic [2:0]        keySizeQ;
    logic [DATA_W-1:0] messageQ;
    logic [DATA_W-1:0] rspMessageQ;
    logic              rspErrorQ;

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    aes_rr_arbiter uArb (
        .reqValid (bus.reqValid),
        .lastGrant(lastGrant),
        .grant    (grant)
    );

    assign accept    = (state == IDLE) && (grant != 2'b00);
    assign keyLegal  = isLegalKeySize(keySizeQ);
    assign ownerMask = owner ? 2'b10 : 2'b01;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = timeoutCntWidth(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] timeoutCnt;

    // Held at zero outside BUSY, so every BUSY visit starts counting from zero.
    always_ff @(posedge clock) begin
        if (reset || (state != BUSY)) begin
            timeoutCnt <= '0;
        end else begin
            timeoutCnt <= timeoutCnt + CNT_W'(1);
        end
    end

    assign timeoutHit = (state == BUSY) && (timeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        bus.reqReady  = 2'b00;
        bus.coreStart = 1'b0;
        bus.rspValid  = 2'b00;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.reqReady = grant;
                bus.busy     = 1'b0;
                if (accept) stateNext = ISSUE;
            end
            ISSUE: begin
                bus.coreStart = keyLegal;
                stateNext     = keyLegal ? BUSY : RESP;
            end
            BUSY: begin
                if (bus.coreDone || timeoutHit) stateNext = RESP;
            end
            RESP: begin
                bus.rspValid = ownerMask;
                if ((bus.rspReady & ownerMask) != 2'b00) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant   <= 1'b1;
            owner       <= 1'b0;
            encOrDecQ   <= 1'b0;
            keySizeQ    <= '0;
            messageQ    <= '0;
            rspMessageQ <= '0;
            rspErrorQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner     <= grant[1];
                        lastGrant <= grant[1];
                        encOrDecQ <= bus.reqEncOrDec[grant[1]];
                        keySizeQ  <= grant[1] ? bus.reqKeySize1 : bus.reqKeySize0;
                        messageQ  <= grant[1] ? bus.reqMessage1 : bus.reqMessage0;
                    end
                end
                ISSUE: begin
                    if (!keyLegal) begin
                        rspMessageQ <= '0;
                        rspErrorQ   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.coreDone) begin
                        rspMessageQ <= bus.coreMessageOut;
                        rspErrorQ   <= 1'b0;
                    end else if (timeoutHit) begin
                        rspMessageQ <= '0;
                        rspErrorQ   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.coreEncOrDec  = encOrDecQ;
    assign bus.coreKeySize   = keySizeQ;
    assign bus.coreMessageIn = messageQ;
    assign bus.rspMessage    = rspMessageQ;
    assign bus.rspError      = rspErrorQ;

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the maximum number of BUSY cycles to wait for coreDone before aborting a job.
REQ-002 clock  input  1  single system clock; all logic SHALL be synchronous to its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqValid  input  2  bit i: requester i presents a job.
REQ-005 reqReady  output  2  bit i: job from requester i accepted this cycle.
REQ-006 reqEncOrDec  input  2  bit i: mode for requester i (1 = encrypt, 0 = decrypt).
REQ-007 reqKeySize0, reqKeySize1  input  3 each  key-size code per requester.
REQ-008 reqMessage0, reqMessage1  input  128 each  message per requester.
REQ-009 coreStart  output  1  one-cycle start pulse to the shared AES core.
REQ-010 coreEncOrDec, coreKeySize, coreMessageIn  output  1/3/128  latched job fields driven to the core.
REQ-011 coreDone  input  1  core completion.
REQ-012 coreMessageOut  input  128  core result, valid while coreDone=1.
REQ-013 rspValid  output  2  bit i: response pending for requester i.
REQ-014 rspReady  input  2  bit i: requester i takes its response.
REQ-015 rspMessage, rspError  output  128/1  response payload and error flag.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, BUSY and RESP.
REQ-018 In IDLE, reqReady SHALL be one-hot or zero; it is asserted combinationally only for the arbitration winner among the reqValid bits.
- Arbitration: a single valid requester wins; if both are valid, the one not equal to lastGrant wins.
REQ-019 On a valid&ready transfer, the block SHALL latch mode, keySize and message, record the owner, update lastGrant, and go to ISSUE.
REQ-020 reqReady SHALL be 0 in ISSUE, BUSY and RESP; one job is in flight at a time.
REQ-021 Legal keySize codes: 3'b100=128, 3'b010=192, 3'b001=256.
- An illegal code is accepted, then the FSM goes ISSUE->RESP with rspError=1, rspMessage=0 and no coreStart.
REQ-022 ISSUE, legal key: coreStart=1 for exactly one cycle, then BUSY.
REQ-023 coreEncOrDec, coreKeySize and coreMessageIn SHALL hold the latched values from ISSUE through the end of RESP.
REQ-024 In BUSY, the first cycle with coreDone=1 SHALL capture coreMessageOut into rspMessage with rspError=0, then RESP.
- Latency: acceptance at cycle T, coreStart at T+1, coreDone at cycle D, rspValid[owner] at D+1.
REQ-025 coreDone SHALL be ignored in IDLE, ISSUE and RESP.
REQ-026 In RESP, only rspValid[owner] SHALL be high, and it SHALL hold rspMessage/rspError stable until rspReady[owner]=1; go to IDLE on the next cycle.
- rspReady on the non-owner bit is ignored.
REQ-027 A new job SHALL NOT be accepted in the same cycle as a response handshake; the earliest acceptance is the next IDLE cycle.

Reset
REQ-028 On reset: state=IDLE, lastGrant=1 (requester 0 wins first tie), reqReady=0, coreStart=0, rspValid=0, rspError=0, rspMessage=0, core outputs=0, timeout counter=0.
REQ-029 Reset in any state SHALL abort the job silently; no response is produced, and a coreDone arriving after reset is ignored.

Configuration
REQ-030 With macro AES_ARB_TIMEOUT_EN defined: a counter cleared on entering BUSY increments each BUSY cycle.
- When it reaches TIMEOUT_CYCLES without coreDone, go to RESP with rspError=1 and rspMessage=0.
REQ-031 Without AES_ARB_TIMEOUT_EN: no counter is built, and BUSY waits indefinitely; rspError arises only from an illegal keySize.

Structure
REQ-032 Shared package aes_arb_pkg SHALL hold the state enumeration, the three legal keySize constants, and the timeout-counter width derived from TIMEOUT_CYCLES.
REQ-033 Two-way round-robin selection SHALL be a sub-module aes_rr_arbiter (inputs reqValid, lastGrant; outputs one-hot grant).

Verification
REQ-034 After reset, reqValid=2'b11 -> reqReady=2'b01.
- coreStart one cycle later with requester 0's fields.
- The following job goes to requester 1 (alternation).
REQ-035 Requester 1 job with keySize=3'b100; core raises coreDone 12 cycles after coreStart with coreMessageOut=X -> rspValid=2'b10 and rspMessage=X, held while rspReady=0 for 5 cycles, cleared the cycle after rspReady[1]=1.
REQ-036 keySize=3'b011 -> no coreStart; rspValid[owner]=1 two cycles after acceptance with rspError=1 and rspMessage=0.
REQ-037 With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, coreDone never asserted -> rspError=1 after 8 BUSY cycles.
- Without the macro: busy stays 1 and rspValid stays 0 for 100 cycles.
REQ-038 Reset asserted during BUSY, then coreDone pulsed -> all outputs at reset values, no rspValid.
- A subsequent job completes normally with the correct owner.
